uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter: arbitrates in IDLE and sends
// one 8N1-style frame per accepted byte, with bit timing taken from s_tick.
module uart_tx_sched #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            req0_valid,
  input  logic [DBIT-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DBIT-1:0] req1_data,
  output logic            req1_ready,
  output logic            tx,
  output logic            busy,
  output logic            grant_id
);

  localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = $clog2(DBIT + 1);
  localparam logic [CW-1:0] OS_LAST  = CW'(OS - 1);
  localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_idx;
  logic [DBIT-1:0] shift;
  logic            last_grant;
  logic            gnt_any;
  logic            gnt_id;

  // Round-robin pick: on contention the requester that did not win last time goes
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end else begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
      end
    end else begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
    end
  end

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any & gnt_id;

  // Frame sequencer; accept starts the start bit immediately, ticks pace the rest
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            shift      <= gnt_id ? req1_data : req0_data;
            grant_id   <= gnt_id;
            last_grant <= gnt_id;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              tx       <= shift[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              if (bit_idx == BIT_LAST) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                shift   <= shift >> 1;
                tx      <= shift[1];
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: frames, arbitration, slow ticks, reset abort,
// ignored valid pulses and a 2-stop-bit instance with a continuous stream.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic [7:0] req1_data = 8'h00;

  logic a_r0, a_r1, a_tx, a_busy, a_gid;
  logic b_r0, b_r1, b_tx, b_busy, b_gid;
  logic r0_s, r1_s, tx_s, busy_s, gid_s;
  logic sel = 1'b0;

  int vecs = 0;
  int errs = 0;
  bit slow = 1'b0;
  int ph = 0;

  always #5 clk = ~clk;

  uart_tx_sched dut_a (
    .clk(clk), .rst(rst), .s_tick(s_tick),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
    .tx(a_tx), .busy(a_busy), .grant_id(a_gid)
  );

  uart_tx_sched #(.SB_TICK(32)) dut_b (
    .clk(clk), .rst(rst), .s_tick(s_tick),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
    .tx(b_tx), .busy(b_busy), .grant_id(b_gid)
  );

  assign r0_s   = sel ? b_r0   : a_r0;
  assign r1_s   = sel ? b_r1   : a_r1;
  assign tx_s   = sel ? b_tx   : a_tx;
  assign busy_s = sel ? b_busy : a_busy;
  assign gid_s  = sel ? b_gid  : a_gid;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // s_tick for the coming posedge: tied high, or one pulse every 163 cycles
  task automatic tick_update();
    if (slow) begin
      ph = (ph == 162) ? 0 : ph + 1;
      s_tick = (ph == 0);
    end else begin
      s_tick = 1'b1;
    end
  endtask

  task automatic step(output bit seen);
    @(negedge clk);
    seen = s_tick;
    tick_update();
  endtask

  function automatic logic exp_tx(input int n, input logic [7:0] d);
    if (n < 16) return 1'b0;
    else if (n < 144) return d[(n - 16) / 16];
    else return 1'b1;
  endfunction

  task automatic do_reset();
    bit seen;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(seen);
    step(seen);
    #1;
    chk("rst_tx", tx_s, 1'b1);
    chk("rst_busy", busy_s, 1'b0);
    chk("rst_gid", gid_s, 1'b0);
    chk("rst_ready0", r0_s, 1'b0);
    chk("rst_ready1", r1_s, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle_watch(input int k);
    bit seen;
    repeat (k) begin
      step(seen);
      chk("idle_tx", tx_s, 1'b1);
      chk("idle_busy", busy_s, 1'b0);
      chk("idle_ready0", r0_s, 1'b0);
      chk("idle_ready1", r1_s, 1'b0);
    end
  endtask

  // Called at an IDLE negedge with the intended requester(s) valid; n counts ticks since accept
  task automatic run_frame(input bit g, input logic [7:0] d, input int sbt,
                           input logic [1:0] drop, input int pulse_at, input int abort_at);
    int n, guard, total;
    bit seen, pulsed, pulse_on;
    total = 144 + sbt;
    n = 0; guard = 0; pulsed = 1'b0; pulse_on = 1'b0;
    #1;
    chk("accept_ready0", r0_s, !g);
    chk("accept_ready1", r1_s, g);
    chk("accept_busy", busy_s, 1'b0);
    step(seen);
    if (drop[0]) req0_valid = 1'b0;
    if (drop[1]) req1_valid = 1'b0;
    forever begin
      if (n == abort_at) begin
        rst = 1'b1;
        step(seen);
        chk("abort_tx", tx_s, 1'b1);
        chk("abort_busy", busy_s, 1'b0);
        chk("abort_gid", gid_s, 1'b0);
        rst = 1'b0;
        return;
      end
      chk("frame_tx", tx_s, exp_tx(n, d));
      chk("frame_busy", busy_s, 1'b1);
      chk("frame_gid", gid_s, g);
      chk("busy_ready0", r0_s, 1'b0);
      chk("busy_ready1", r1_s, 1'b0);
      if (n == pulse_at && !pulsed) begin
        req0_valid = 1'b1;
        pulsed = 1'b1;
        pulse_on = 1'b1;
        #1;
        chk("pulse_ready0", r0_s, 1'b0);
      end
      step(seen);
      if (pulse_on) begin
        req0_valid = 1'b0;
        pulse_on = 1'b0;
      end
      if (seen) n++;
      guard++;
      if (guard > total * 170) begin
        vecs++;
        errs++;
        $error("FAIL frame_timeout: observed %0d ticks expected %0d", n, total);
        return;
      end
      if (n == total) break;
    end
    chk("end_busy", busy_s, 1'b0);
    chk("end_tx", tx_s, 1'b1);
    chk("end_gid", gid_s, g);
  endtask

  initial begin
    do_reset();

    // single req0 frame, tied ticks
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    run_frame(1'b0, 8'hA5, 16, 2'b01, -1, -1);
    idle_watch(5);

    // contention from reset: req0, req1, req0
    do_reset();
    req0_data = 8'h11;
    req1_data = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    run_frame(1'b0, 8'h11, 16, 2'b00, -1, -1);
    run_frame(1'b1, 8'h22, 16, 2'b00, -1, -1);
    run_frame(1'b0, 8'h11, 16, 2'b11, -1, -1);
    idle_watch(3);

    // req0 pulsed while req1 frame in flight: never accepted
    req1_data = 8'h3C;
    req1_valid = 1'b1;
    run_frame(1'b1, 8'h3C, 16, 2'b10, 40, -1);
    idle_watch(20);

    // slow ticks, one every 163 cycles
    slow = 1'b1;
    ph = 0;
    req1_data = 8'h00;
    req1_valid = 1'b1;
    run_frame(1'b1, 8'h00, 16, 2'b10, -1, -1);
    slow = 1'b0;
    s_tick = 1'b1;
    idle_watch(3);

    // reset during data bit 3, then req0 wins contention again
    req0_data = 8'hC3;
    req0_valid = 1'b1;
    run_frame(1'b0, 8'hC3, 16, 2'b00, -1, 69);
    req1_data = 8'h5A;
    req1_valid = 1'b1;
    run_frame(1'b0, 8'hC3, 16, 2'b01, -1, -1);
    run_frame(1'b1, 8'h5A, 16, 2'b10, -1, -1);
    idle_watch(3);

    // two stop bits, continuous req0 stream
    sel = 1'b1;
    do_reset();
    req0_data = 8'h96;
    req0_valid = 1'b1;
    run_frame(1'b0, 8'h96, 32, 2'b00, -1, -1);
    run_frame(1'b0, 8'h96, 32, 2'b01, -1, -1);
    idle_watch(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
